// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add/sub controller.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Requester-side handshake and operand/result bus of the serial adder.
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // requester drives the operation, reads back status and result
    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    // controller side
    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );

endinterface

// File: rtl/serial_add_ctrl_full_adder_cell.sv
// One-bit full adder, the single arithmetic cell time-shared over all bits.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // plain sum and majority carry
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor controller: latches operands, walks the shared
// full-adder cell over WIDTH bits LSB first, then reports sum/cout/ovf.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    serial_add_ctrl_if.slave   bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    // bits already produced; the newest bit is prepended each RUN cycle
    logic [WIDTH-2:0] res;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             cell_s;
    logic             cell_cout;
    logic             accept;
    logic             last;

    // DONE accepts a new start exactly like IDLE; RUN never does
    assign accept   = (state != RUN) && bus.start;
    assign last     = (state == RUN) && (count == CW'(WIDTH - 1));
    assign res_next = {cell_s, res};

    full_adder_cell u_cell (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .s    (cell_s),
        .cout (cell_cout)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // operand/carry/count sequencing and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            op_a   <= '0;
            op_b   <= '0;
            carry  <= 1'b0;
            res    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            // subtraction is a + ~b + 1, so cin is forced high
            op_a  <= bus.a;
            op_b  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub ? 1'b1 : bus.cin;
            count <= '0;
        end else if (state == RUN) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            carry <= cell_cout;
            res   <= res_next[WIDTH-1:1];
            if (last) begin
                // carry register still holds the carry into the MSB here
                sum_q  <= res_next;
                cout_q <= cell_cout;
                ovf_q  <= carry ^ cell_cout;
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed vectors,
// a cycle-level arithmetic model compared every cycle, and literal results.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    // expected result from plain integer arithmetic: {cout, ovf, sum}
    function automatic logic [W+1:0] calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
        logic [W-1:0] bb;
        logic [W:0]   tot;
        logic         ov;
        bb  = sub ? ~b : b;
        tot = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        ov  = (a[W-1] == bb[W-1]) && (tot[W-1] != a[W-1]);
        return {tot[W], ov, tot[W-1:0]};
    endfunction

    // model: an accepted op takes W cycles, then results appear with a done pulse
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf  = 1'b0;
    logic [W+1:0] pend   = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    {m_cout, m_ovf, m_sum} <= pend;
                end
            end else if (bus.start) begin
                pend   <= calc(bus.a, bus.b, bus.cin, bus.sub);
                m_left <= W;
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // advance to the next falling edge and compare every output with the model
    task automatic tick();
        @(negedge clk);
        if (bus.done === 1'b1) done_cnt++;
        check("busy", W'(bus.busy), W'(m_left > 0));
        check("done", W'(bus.done), W'(m_done));
        check("sum",  bus.sum, m_sum);
        check("cout", W'(bus.cout), W'(m_cout));
        check("ovf",  W'(bus.ovf), W'(m_ovf));
    endtask

    // count cycles until done, bounded
    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.done !== 1'b1 && n < 40);
        check("done_seen", W'(bus.done), W'(1));
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input logic [W-1:0] e_sum,
                          input logic e_cout, input logic e_ovf);
        int n;
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({name, "_busy"}, W'(bus.busy), W'(1));
        wait_done(n);
        check({name, "_lat"},  W'(n), W'(8));
        check({name, "_sum"},  bus.sum, e_sum);
        check({name, "_cout"}, W'(bus.cout), W'(e_cout));
        check({name, "_ovf"},  W'(bus.ovf), W'(e_ovf));
    endtask

    initial begin
        int n;
        int d0;
        reset = 1'b1;
        bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", W'(bus.busy), W'(0));
        check("rst_sum",  bus.sum, W'(0));

        // basic add, carry-out, signed overflow, subtraction with/without borrow
        run_op("add1",  8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0);
        run_op("addc",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("addv",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("sub1",  8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("subv",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        run_op("cin1",  8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("subci", 8'h10, 8'h10, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);

        // start during RUN is ignored
        d0 = done_cnt;
        bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        bus.a = 8'hAA; bus.b = 8'h55; bus.sub = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(n);
        check("ign_sum", bus.sum, 8'h46);
        repeat (12) tick();
        check("ign_pulses", W'(done_cnt - d0), W'(1));

        // reset mid-RUN aborts and clears outputs
        d0 = done_cnt;
        bus.a = 8'h55; bus.b = 8'h22; bus.sub = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", W'(bus.busy), W'(0));
        check("abort_done", W'(bus.done), W'(0));
        check("abort_sum",  bus.sum, W'(0));
        check("abort_cout", W'(bus.cout), W'(0));
        check("abort_ovf",  W'(bus.ovf), W'(0));
        repeat (10) tick();
        check("abort_nodone", W'(done_cnt - d0), W'(0));
        run_op("post", 8'h21, 8'h11, 1'b0, 1'b0, 8'h32, 1'b0, 1'b0);

        // start held through DONE re-enters RUN immediately
        bus.a = 8'h01; bus.b = 8'h02; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
        tick();
        bus.a = 8'h10; bus.b = 8'h20;
        wait_done(n);
        check("b2b_lat1", W'(n), W'(8));
        check("b2b_sum1", bus.sum, 8'h03);
        tick();
        bus.start = 1'b0;
        check("b2b_busy", W'(bus.busy), W'(1));
        wait_done(n);
        check("b2b_lat2", W'(n), W'(8));
        check("b2b_sum2", bus.sum, 8'h30);
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
